spi_byte_tx: RTL and testbench

- SPI transmit master: the sending end of the spi_mosi/spi_clk byte link that the GDU-side SPI receiver captures.
- Accepts bytes from a host-side producer through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte MSB-first on spi_mosi, with generated spi_clk and a per-byte spi_cs frame.
- Used by test/host logic to drive display commands into the TTO top level.

---
 rtl/spi_byte_tx.sv | 154 +++++++++++++++
 tb/tb_spi_byte_tx.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: SPI mode-0 byte transmitter with a small input FIFO.
// Each byte goes out MSB first inside its own spi_cs frame.
module spi_byte_tx #(
  parameter int CLK_DIV    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_HALF   = 2
) (
  input  logic                        clk_24m,
  input  logic                        rst_n,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        spi_clk,
  output logic                        spi_mosi,
  output logic                        spi_cs
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 12;
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_HALF * CLK_DIV);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop, empty;
  logic [7:0]    head;

  state_e        state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [3:0]    half_q, half_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          tick;

  assign o_ready = cnt_q < DEPTH_C;
  assign empty   = cnt_q == '0;
  assign push    = i_valid & o_ready;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_24m) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign tick = tmr_q == HALF_END;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    half_d  = half_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tick) begin
          tmr_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          tmr_d  = '0;
          half_d = half_q + 1'b1;
          if (half_q == 4'd15) begin
            state_d = GAP;
            done_d  = 1'b1;
          end else if (!half_q[0] && half_q != 4'd14) begin
            // falling edge: present the next bit; bit 0 is held to the end
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      GAP: begin
        // extra decision cycle keeps the pitch equal to the IDLE pop latency
        if (tmr_q == GAP_END) begin
          tmr_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      tmr_q    <= '0;
      half_q   <= '0;
      shift_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      half_q   <= half_d;
      shift_q  <= shift_d;
      done_q   <= done_d;
    end
  end

  assign spi_cs     = (state_q == LOAD) || (state_q == SHIFT);
  assign spi_clk    = (state_q == SHIFT) && !half_q[0];
  assign spi_mosi   = spi_cs && shift_q[7];
  assign o_done     = done_q;
  assign o_busy     = (state_q != IDLE) || !empty;
  assign o_fifo_cnt = cnt_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: randomized bench with a frame-level SPI monitor.
// Expected bytes come from a queue fed by accepted handshakes.
module tb_spi_byte_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0] d0 = '0;
  logic       v0 = 1'b0;
  logic       r0, busy0, done0, sclk0, mosi0, cs0;
  logic [2:0] c0;

  logic [7:0] d_1 = '0;
  logic       v_1 = 1'b0;
  logic       r_1, busy_1, done_1, sclk_1, mosi_1, cs_1;
  logic [2:0] c_1;

  logic [7:0] d_12 = '0;
  logic       v_12 = 1'b0;
  logic       r_12, busy_12, done_12, sclk_12, mosi_12, cs_12;
  logic [2:0] c_12;

  always #5 clk = ~clk;

  spi_byte_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .GAP_HALF(2)) u_dut (
    .clk_24m(clk), .rst_n(rst_n), .i_data(d0), .i_valid(v0),
    .o_ready(r0), .o_fifo_cnt(c0), .o_busy(busy0), .o_done(done0),
    .spi_clk(sclk0), .spi_mosi(mosi0), .spi_cs(cs0)
  );

  spi_byte_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .GAP_HALF(2)) u_d1 (
    .clk_24m(clk), .rst_n(rst_n), .i_data(d_1), .i_valid(v_1),
    .o_ready(r_1), .o_fifo_cnt(c_1), .o_busy(busy_1), .o_done(done_1),
    .spi_clk(sclk_1), .spi_mosi(mosi_1), .spi_cs(cs_1)
  );

  spi_byte_tx #(.CLK_DIV(12), .FIFO_DEPTH(4), .GAP_HALF(2)) u_d12 (
    .clk_24m(clk), .rst_n(rst_n), .i_data(d_12), .i_valid(v_12),
    .o_ready(r_12), .o_fifo_cnt(c_12), .o_busy(busy_12), .o_done(done_12),
    .spi_clk(sclk_12), .spi_mosi(mosi_12), .spi_cs(cs_12)
  );

  int total = 0;
  int passed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         len_q[$];
  int         gap_q[$];
  int         nr_q[$];
  int         done_cnt = 0;
  int         out_err = 0;

  logic [7:0] m_sh;
  int         m_len, m_low, m_nr;
  logic       m_pc, m_pcs;
  bit         framed = 0;

  // frame monitor for the CLK_DIV=2 instance
  always @(negedge clk) begin
    if (!rst_n) begin
      m_sh = '0; m_len = 0; m_low = 0; m_nr = 0;
      m_pc = 1'b0; m_pcs = 1'b0; framed = 0;
    end else begin
      if (done0) done_cnt++;
      if (sclk0 && !cs0) out_err++;
      if (cs0) begin
        if (!m_pcs && framed) gap_q.push_back(m_low);
        m_len++;
        if (sclk0 && !m_pc) begin
          m_sh = {m_sh[6:0], mosi0};
          m_nr++;
        end
      end else begin
        if (m_pcs) begin
          rx_q.push_back(m_sh);
          len_q.push_back(m_len);
          nr_q.push_back(m_nr);
          framed = 1;
          m_low = 0; m_len = 0; m_nr = 0;
        end
        m_low++;
      end
      m_pc = sclk0;
      m_pcs = cs0;
    end
  end

  task automatic clear_mon();
    exp_q.delete(); rx_q.delete(); len_q.delete();
    gap_q.delete(); nr_q.delete();
    framed = 0;
    out_err = 0;
  endtask

  task automatic drive(input logic [7:0] d);
    d0 = d;
    v0 = 1'b1;
    if (r0 === 1'b1) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy0 && !cs0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (r0 !== 1'b1) $display("FAIL rst_ready got %b want 1", r0);
    else passed++;
    total++;
    if (c0 !== 3'd0) $display("FAIL rst_cnt got %0d want 0", c0);
    else passed++;
    total++;
    if ({busy0, done0, sclk0, mosi0, cs0} !== 5'b0)
      $display("FAIL rst_outs got %b want 00000",
               {busy0, done0, sclk0, mosi0, cs0});
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy0, cs0, sclk0, c0} !== 6'b0)
      $display("FAIL post_rst got %b want 0", {busy0, cs0, sclk0, c0});
    else passed++;
  endtask

  task automatic test_single();
    bit ok;
    int base;
    clear_mon();
    base = done_cnt;
    @(negedge clk);
    drive(8'hA5);
    v0 = 1'b0;
    total++;
    if (cs0 !== 1'b0 || busy0 !== 1'b1)
      $display("FAIL single_lat0 cs=%b busy=%b want cs=0 busy=1", cs0, busy0);
    else passed++;
    @(negedge clk);
    total++;
    if (cs0 !== 1'b1 || mosi0 !== 1'b1 || sclk0 !== 1'b0)
      $display("FAIL single_lat1 cs=%b mosi=%b clk=%b want 1 1 0",
               cs0, mosi0, sclk0);
    else passed++;
    wait_idle(200, ok);
    total++;
    if (!ok) $display("FAIL single_idle timeout got busy=%b want 0", busy0);
    else passed++;
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || nr_q[0] != 8)
      $display("FAIL single_data got n=%0d byte=%h want n=1 byte=a5 edges=8",
               rx_q.size(), rx_q.size() ? rx_q[0] : 8'h0);
    else passed++;
    total++;
    if (len_q.size() != 1 || len_q[0] != 34)
      $display("FAIL single_cslen got %0d want 34",
               len_q.size() ? len_q[0] : -1);
    else passed++;
    total++;
    if (done_cnt - base != 1 || out_err != 0)
      $display("FAIL single_done got done=%0d clkerr=%0d want 1 0",
               done_cnt - base, out_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    clear_mon();
    base = done_cnt;
    @(negedge clk);
    drive(8'h00);
    drive(8'hFF);
    drive(8'h3C);
    v0 = 1'b0;
    wait_idle(400, ok);
    total++;
    if (!ok || rx_q.size() != 3 || exp_q.size() != 3)
      $display("FAIL b2b_count got %0d want 3", rx_q.size());
    else passed++;
    for (int i = 0; i < 3 && i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i] || len_q[i] != 34)
        $display("FAIL b2b_byte%0d got %h len %0d want %h len 34",
                 i, rx_q[i], len_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (gap_q.size() != 2 || gap_q[0] != 5 || gap_q[1] != 5)
      $display("FAIL b2b_gap got n=%0d first=%0d want 2 gaps of 5",
               gap_q.size(), gap_q.size() ? gap_q[0] : -1);
    else passed++;
    total++;
    if (done_cnt - base != 3)
      $display("FAIL b2b_done got %0d want 3", done_cnt - base);
    else passed++;
  endtask

  task automatic test_random();
    bit ok;
    clear_mon();
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(8'($urandom_range(0, 255)));
      v0 = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    v0 = 1'b0;
    wait_idle(2000, ok);
    total++;
    if (!ok || rx_q.size() != exp_q.size())
      $display("FAIL rand_count got %0d want %0d", rx_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL rand_byte%0d got %h want %h", i, rx_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_fill();
    bit ok;
    int acc;
    clear_mon();
    acc = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        total++;
        if (r0 !== 1'b0 || c0 !== 3'd4)
          $display("FAIL fill_full got ready=%b cnt=%0d want 0 4", r0, c0);
        else passed++;
      end
      if (r0 === 1'b1) acc++;
      drive(8'($urandom_range(0, 255)));
    end
    v0 = 1'b0;
    total++;
    if (acc != 5) $display("FAIL fill_accept got %0d want 5", acc);
    else passed++;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (c0 !== 3'd4) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok || c0 !== 3'd3 || r0 !== 1'b1)
      $display("FAIL fill_pop got cnt=%0d ready=%b want 3 1", c0, r0);
    else passed++;
    wait_idle(800, ok);
    total++;
    if (!ok || rx_q.size() != 5 || exp_q.size() != 5)
      $display("FAIL fill_count got %0d want 5", rx_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL fill_byte%0d got %h want %h", i, rx_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    int phase;
    clear_mon();
    phase = 0;
    ok = 0;
    @(negedge clk);
    for (int i = 0; i < 300 && !ok; i++) begin
      if (phase == 2) begin
        v0 = 1'b0;
        total++;
        if (c0 !== 3'd4 || r0 !== 1'b0)
          $display("FAIL fullpop_refill got cnt=%0d ready=%b want 4 0", c0, r0);
        else passed++;
        ok = 1;
      end else begin
        if (phase == 1 && c0 === 3'd3) begin
          total++;
          if (r0 !== 1'b1)
            $display("FAIL fullpop_ready got %b want 1", r0);
          else passed++;
          phase = 2;
        end
        if (phase == 0 && c0 === 3'd4) phase = 1;
        drive(8'($urandom_range(0, 255)));
      end
    end
    v0 = 1'b0;
    total++;
    if (!ok) $display("FAIL fullpop_timeout got phase=%0d want 2", phase);
    else passed++;
    wait_idle(800, ok);
    total++;
    if (!ok || rx_q.size() != 6 || exp_q.size() != 6)
      $display("FAIL fullpop_count got %0d want 6", rx_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL fullpop_byte%0d got %h want %h", i, rx_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n, base;
    logic pc;
    clear_mon();
    @(negedge clk);
    drive(8'h81);
    drive(8'h11);
    v0 = 1'b0;
    n = 0;
    pc = 1'b0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      if (sclk0 && !pc) n++;
      pc = sclk0;
      if (n < 3) @(negedge clk);
    end
    #2;
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    total++;
    if (n != 3 || {sclk0, mosi0, cs0, done0} !== 4'b0)
      $display("FAIL midrst_outs got edges=%0d %b want 3 0000",
               n, {sclk0, mosi0, cs0, done0});
    else passed++;
    total++;
    if (c0 !== 3'd0 || r0 !== 1'b1)
      $display("FAIL midrst_fifo got cnt=%0d ready=%b want 0 1", c0, r0);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (done_cnt != base || rx_q.size() != 0 || busy0 !== 1'b0)
      $display("FAIL midrst_discard got done=%0d rx=%0d busy=%b want 0 0 0",
               done_cnt - base, rx_q.size(), busy0);
    else passed++;
    clear_mon();
    drive(8'h42);
    v0 = 1'b0;
    wait_idle(200, ok);
    total++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h42 || done_cnt - base != 1)
      $display("FAIL midrst_next got n=%0d byte=%h done=%0d want 1 42 1",
               rx_q.size(), rx_q.size() ? rx_q[0] : 8'h0, done_cnt - base);
    else passed++;
  endtask

  task automatic test_clkdiv(input int which, input int cd);
    logic [7:0] sh;
    int len, bad, nr, run;
    logic lvl, c, m, cs;
    bit in_f, ok;
    sh = '0; len = 0; bad = 0; nr = 0; run = 0;
    lvl = 1'b0; in_f = 0; ok = 0;
    @(negedge clk);
    if (which == 1) begin d_1 = 8'h5A; v_1 = 1'b1; end
    else begin d_12 = 8'h5A; v_12 = 1'b1; end
    @(negedge clk);
    v_1 = 1'b0;
    v_12 = 1'b0;
    for (int i = 0; i < 40 * cd + 50; i++) begin
      cs = (which == 1) ? cs_1 : cs_12;
      c  = (which == 1) ? sclk_1 : sclk_12;
      m  = (which == 1) ? mosi_1 : mosi_12;
      if (cs) begin
        if (in_f && c != lvl) begin
          if (run != cd) bad++;
          run = 0;
        end
        if (c && !lvl) begin
          sh = {sh[6:0], m};
          nr++;
        end
        lvl = c;
        run++;
        len++;
        in_f = 1;
      end else if (in_f) begin
        if (run != cd) bad++;
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok || len != 17 * cd)
      $display("FAIL div%0d_cslen got %0d want %0d", cd, len, 17 * cd);
    else passed++;
    total++;
    if (bad != 0)
      $display("FAIL div%0d_half got %0d bad half-periods want 0", cd, bad);
    else passed++;
    total++;
    if (nr != 8 || sh !== 8'h5A)
      $display("FAIL div%0d_data got edges=%0d byte=%h want 8 5a", cd, nr, sh);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_fill();
    test_full_pop();
    test_reset_mid();
    test_clkdiv(1, 1);
    test_clkdiv(12, 12);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
